camo_key_loader: RTL and testbench

// Serial loader that drives the 2-bit function-select (key) inputs of camouflaged

---
 rtl/camo_key_loader.sv | 197 +++++++++++++++++++
 tb/tb_camo_key_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/camo_key_loader.sv
// Serial key loader for camouflaged-cell function selects.
// Bits arrive LSB first over a valid/ready handshake, followed by one even-parity
// bit. A passing key is committed atomically to the held select bus. A failing
// parity check, an idle timeout, or a start while locked sets the sticky error.
// The parity decision is registered once before it is applied to the outputs,
// so results appear two edges after the parity bit is accepted.
module camo_key_loader #(
    parameter int                       NUM_CELLS   = 6,
    parameter logic [2*NUM_CELLS-1:0]   DEFAULT_KEY = {(2*NUM_CELLS){1'b0}},
    parameter int                       TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_start,
    input  logic                        key_bit,
    input  logic                        key_bit_valid,
    output logic                        key_bit_ready,
    input  logic                        lock_req,
    output logic [2*NUM_CELLS-1:0]      sel_out,
    output logic                        sel_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        locked
);

    localparam int KEY_W  = 2 * NUM_CELLS;
    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Even parity holds when the key bits and the parity bit XOR to zero.
    function automatic logic parity_ok(input logic [KEY_W-1:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic               parity_q, parity_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [KEY_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               locked_q, locked_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               xfer_s;

    assign xfer_s = key_bit_valid & ready_q;

    // Next-state, shift register, timeout and commit logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        shadow_d    = shadow_q;
        parity_d    = parity_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;

        // Apply the parity decision registered during the previous CHECK cycle.
        if (pass_q) begin
            sel_d       = shadow_q;
            sel_valid_d = 1'b1;
            done_d      = 1'b1;
        end else if (fail_q) begin
            err_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (key_start) begin
                    if (locked_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_SHIFT;
                        cnt_d    = {CNT_W{1'b0}};
                        idle_d   = {IDLE_W{1'b0}};
                        shadow_d = {KEY_W{1'b0}};
                        err_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (key_start) begin
                    // Restart: any bit presented in the same cycle is dropped.
                    cnt_d    = {CNT_W{1'b0}};
                    idle_d   = {IDLE_W{1'b0}};
                    shadow_d = {KEY_W{1'b0}};
                end else if (xfer_s) begin
                    idle_d = {IDLE_W{1'b0}};
                    if (cnt_q < CNT_W'(KEY_W)) begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shadow_d[i] = key_bit;
                            end else begin
                                shadow_d[i] = shadow_q[i];
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        parity_d = key_bit;
                        state_d  = ST_CHECK;
                    end
                end else if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
                    // Sender went quiet for TIMEOUT cycles: abandon the load.
                    state_d = ST_IDLE;
                    idle_d  = {IDLE_W{1'b0}};
                    err_d   = 1'b1;
                end else if (idle_q != {IDLE_W{1'b1}}) begin
                    idle_d = idle_q + IDLE_W'(1);
                end else begin
                    idle_d = idle_q;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (parity_ok(shadow_q, parity_q)) begin
                    pass_d = 1'b1;
                end else begin
                    fail_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lock is sticky and only honoured once a checked key is (being) committed.
    always_comb begin
        locked_d = locked_q | (lock_req & (sel_valid_q | pass_q));
        ready_d  = (state_d == ST_SHIFT);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            idle_q      <= {IDLE_W{1'b0}};
            shadow_q    <= {KEY_W{1'b0}};
            parity_q    <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            sel_q       <= DEFAULT_KEY;
            sel_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            shadow_q    <= shadow_d;
            parity_q    <= parity_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign key_bit_ready = ready_q;
    assign sel_out       = sel_q;
    assign sel_valid     = sel_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_camo_key_loader.sv
// Self-checking bench for camo_key_loader: directed scenarios plus randomized
// loads, compared against a transaction-level model of the committed key state.
module tb_camo_key_loader;

    localparam int NUM_CELLS = 6;
    localparam int KEY_W     = 12;
    localparam int TIMEOUT   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_start;
    logic             key_bit;
    logic             key_bit_valid;
    logic             key_bit_ready;
    logic             lock_req;
    logic [KEY_W-1:0] sel_out;
    logic             sel_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             locked;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the outputs should hold between loads.
    logic [KEY_W-1:0] m_sel;
    logic             m_valid;
    logic             m_locked;
    logic             m_err;

    always #5 clk = ~clk;

    camo_key_loader #(
        .NUM_CELLS   (NUM_CELLS),
        .DEFAULT_KEY (12'h000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .key_bit_ready (key_bit_ready),
        .lock_req      (lock_req),
        .sel_out       (sel_out),
        .sel_valid     (sel_valid),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .locked        (locked)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_sel"},    32'(sel_out),   32'(m_sel));
        check_val({tag, "_valid"},  32'(sel_valid), 32'(m_valid));
        check_val({tag, "_err"},    32'(err),       32'(m_err));
        check_val({tag, "_locked"}, 32'(locked),    32'(m_locked));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_sel = 12'h000; m_valid = 1'b0; m_locked = 1'b0; m_err = 1'b0;
        check_val({tag, "_busy"},  32'(busy),          32'd0);
        check_val({tag, "_ready"}, 32'(key_bit_ready), 32'd0);
        check_val({tag, "_done"},  32'(done),          32'd0);
        check_outputs(tag);
    endtask

    task automatic pulse_lock(input string tag);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        if (m_valid) m_locked = 1'b1;
        check_outputs(tag);
    endtask

    // One complete load attempt. to_idx >= 0 inserts a TIMEOUT-long gap before
    // that bit; restart_at >= 0 sends that many junk bits and restarts first.
    task automatic do_load(input logic [KEY_W-1:0] key, input logic par,
                           input int gap_lo, input int gap_hi, input int to_idx,
                           input int restart_at, input bit lock_in_check, input string tag);
        int gap;
        bit pass;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        if (m_locked) begin
            m_err = 1'b1;
            check_val({tag, "_lk_busy"},  32'(busy),          32'd0);
            check_val({tag, "_lk_ready"}, 32'(key_bit_ready), 32'd0);
            check_outputs({tag, "_lk"});
            return;
        end
        m_err = 1'b0;
        check_val({tag, "_st_busy"},  32'(busy),          32'd1);
        check_val({tag, "_st_ready"}, 32'(key_bit_ready), 32'd1);
        check_val({tag, "_st_err"},   32'(err),           32'd0);
        if (restart_at >= 0) begin
            for (int i = 0; i < restart_at; i++) begin
                key_bit = 1'($urandom);
                key_bit_valid = 1'b1;
                tick();
            end
            key_start = 1'b1;
            key_bit = 1'($urandom);
            key_bit_valid = 1'b1;
            tick();
            key_start = 1'b0;
            key_bit_valid = 1'b0;
            check_val({tag, "_rs_busy"}, 32'(busy), 32'd1);
        end
        for (int i = 0; i <= KEY_W; i++) begin
            gap = (i == to_idx) ? TIMEOUT : int'($urandom_range(gap_hi, gap_lo));
            key_bit_valid = 1'b0;
            repeat (gap) tick();
            if (i == to_idx) begin
                m_err = 1'b1;
                check_val({tag, "_to_ready"}, 32'(key_bit_ready), 32'd0);
                check_val({tag, "_to_busy"},  32'(busy),          32'd0);
                check_outputs({tag, "_to"});
                return;
            end
            key_bit = (i < KEY_W) ? key[i] : par;
            key_bit_valid = 1'b1;
            tick();
            key_bit_valid = 1'b0;
        end
        check_val({tag, "_n0_done"},  32'(done),          32'd0);
        check_val({tag, "_n0_busy"},  32'(busy),          32'd1);
        check_val({tag, "_n0_ready"}, 32'(key_bit_ready), 32'd0);
        tick();
        check_val({tag, "_n1_done"}, 32'(done), 32'd0);
        if (lock_in_check) lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        pass = (($countones(key) + int'(par)) % 2) == 0;
        if (pass) begin
            m_sel = key;
            m_valid = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        if (lock_in_check && m_valid) m_locked = 1'b1;
        check_val({tag, "_n2_done"}, 32'(done), 32'(pass));
        check_outputs({tag, "_n2"});
        tick();
        check_val({tag, "_n3_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        logic             gp;
        int               act;
        rst_n = 1'b0; key_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0; lock_req = 1'b0;
        tick();
        do_reset("reset");

        // Lock request without a valid key has no effect.
        pulse_lock("lock_novalid");

        // Good load, then bad parity on the same bits.
        do_load(12'hA5C, 1'b0, 0, 0, -1, -1, 1'b0, "good");
        do_load(12'hA5C, 1'b1, 0, 0, -1, -1, 1'b0, "badpar");

        // Backpressure gaps of 3 succeed; 8-cycle gap before bit 6 times out.
        do_load(12'h5A3, 1'b0, 3, 3, -1, -1, 1'b0, "gap3");
        do_load(12'h0F0, 1'b0, 0, 3, 6, -1, 1'b0, "timeout");

        // Restart after 7 bits.
        do_load(12'h3C3, 1'b0, 0, 0, -1, 7, 1'b0, "restart");

        // Lock a committed key, then a new start is refused.
        do_load(12'hA5C, 1'b0, 0, 1, -1, -1, 1'b0, "prelock");
        pulse_lock("lock");
        do_load(12'h123, 1'b0, 0, 0, -1, -1, 1'b0, "locked_start");

        // Reset in the middle of a load after a commit.
        do_reset("reset2");
        do_load(12'hA5C, 1'b0, 0, 0, -1, -1, 1'b0, "premid");
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_bit = 1'($urandom);
            key_bit_valid = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0;
        do_reset("midreset");

        // Lock requested in the commit cycle of the first key after reset.
        do_load(12'h6B1, ^12'h6B1, 0, 2, -1, -1, 1'b1, "lock_commit");
        do_reset("reset3");

        // Randomized loads.
        for (int it = 0; it < 30; it++) begin
            k   = KEY_W'($urandom);
            gp  = ^k;
            act = int'($urandom_range(3, 0));
            case (act)
                0: do_load(k, gp,  0, 3, -1, -1, 1'b0, "rnd_good");
                1: do_load(k, ~gp, 0, 3, -1, -1, 1'b0, "rnd_bad");
                2: do_load(k, gp,  0, 3, int'($urandom_range(KEY_W, 0)), -1, 1'b0, "rnd_to");
                default: do_load(k, gp, 0, 2, -1, int'($urandom_range(KEY_W - 1, 0)), 1'b0, "rnd_rs");
            endcase
            if ($urandom_range(7, 0) == 0) begin
                pulse_lock("rnd_lock");
                do_load(KEY_W'($urandom), 1'b0, 0, 0, -1, -1, 1'b0, "rnd_lkstart");
                do_reset("rnd_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
